// File: rtl/etroc2_fifo_word_packer.sv
// Repacks groups of four 40-bit ETROC2 FIFO words into five 32-bit words on a
// valid/ready stream. Partial groups are padded and emitted on flush or idle timeout.
module etroc2_fifo_word_packer #(
    parameter int unsigned FLUSH_TIMEOUT = 1024,
    parameter logic [39:0] PAD_WORD      = 40'hFFFFFFFFFF
) (
    input  logic        clk40,
    input  logic        reset,
    input  logic        enable,
    input  logic        flush,
    input  logic        fifo_empty,
    input  logic [39:0] fifo_dout,
    output logic        fifo_rd_en,
    output logic [31:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        busy,
    output logic [31:0] group_count,
    output logic [15:0] pad_count
);

    typedef enum logic {FILL, EMIT} packerState_t;

    packerState_t state;
    logic [2:0]   loaded;
    logic         inflight;
    logic         flushPending;
    logic [2:0]   wordIdx;
    logic [31:0]  timeoutCnt;

    logic [2:0]   occupancy;
    logic         timeoutCounting;
    logic         timeoutHit;
    logic         flushReq;
    logic         padNow;
    logic [16:0]  padSum;
    logic [159:0] groupBits;
    logic [31:0]  word [5];

    assign occupancy = loaded + {2'b00, inflight};

    // Gating with reset keeps the read strobe quiet while reset is held.
    assign fifo_rd_en = reset && (state == FILL) && enable && !fifo_empty
                        && (occupancy < 3'd4) && !flushPending;

    assign timeoutCounting = (state == FILL) && (loaded != 3'd0) && (loaded < 3'd4) && fifo_empty;
    assign timeoutHit      = (FLUSH_TIMEOUT != 0) && timeoutCounting
                             && (timeoutCnt == 32'(FLUSH_TIMEOUT) - 32'd1);
    assign flushReq        = (flush || timeoutHit) && (state == FILL) && (occupancy != 3'd0);
    assign padNow          = (state == FILL) && flushPending && !inflight && (loaded < 3'd4);
    assign padSum          = {1'b0, pad_count} + 17'(3'd4 - loaded);

    assign busy = (loaded != 3'd0) || inflight || (state == EMIT);

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : slotGen
        logic [39:0] s;
        always_ff @(posedge clk40) begin
            if (!reset) begin
                s <= '0;
            end else if (state == FILL && inflight && loaded == 3'(gi)) begin
                s <= fifo_dout;
            end else if (padNow && loaded <= 3'(gi)) begin
                s <= PAD_WORD;
            end
        end
    end

    assign groupBits = {slotGen[0].s, slotGen[1].s, slotGen[2].s, slotGen[3].s};

    for (gi = 0; gi < 5; gi++) begin : wordGen
        assign word[gi] = groupBits[159 - 32*gi -: 32];
    end

    always_ff @(posedge clk40) begin
        if (!reset) begin
            state        <= FILL;
            loaded       <= 3'd0;
            inflight     <= 1'b0;
            flushPending <= 1'b0;
            wordIdx      <= 3'd0;
            timeoutCnt   <= '0;
            dout         <= '0;
            dout_valid   <= 1'b0;
            group_count  <= '0;
            pad_count    <= '0;
        end else begin
            inflight <= fifo_rd_en;
            case (state)
                FILL: begin
                    wordIdx <= 3'd0;
                    if (fifo_rd_en || timeoutHit) begin
                        timeoutCnt <= '0;
                    end else if (timeoutCounting) begin
                        timeoutCnt <= timeoutCnt + 32'd1;
                    end
                    if (flushReq) begin
                        flushPending <= 1'b1;
                    end
                    // A landing word takes priority; padding waits for inflight to clear.
                    if (inflight) begin
                        loaded <= loaded + 3'd1;
                        if (loaded == 3'd3) begin
                            state      <= EMIT;
                            timeoutCnt <= '0;
                        end
                    end else if (padNow) begin
                        loaded     <= 3'd4;
                        pad_count  <= padSum[16] ? 16'hFFFF : padSum[15:0];
                        state      <= EMIT;
                        timeoutCnt <= '0;
                    end
                end
                EMIT: begin
                    timeoutCnt <= '0;
                    if (!dout_valid) begin
                        dout       <= word[0];
                        dout_valid <= 1'b1;
                    end else if (dout_ready) begin
                        if (wordIdx == 3'd4) begin
                            dout_valid   <= 1'b0;
                            group_count  <= group_count + 32'd1;
                            loaded       <= 3'd0;
                            flushPending <= 1'b0;
                            state        <= FILL;
                        end else begin
                            wordIdx <= wordIdx + 3'd1;
                            dout    <= word[wordIdx + 3'd1];
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_etroc2_fifo_word_packer.sv
// Scoreboard bench: a queue-based FIFO feeds the packer, a group-level model predicts
// the 32-bit output stream, and a negedge monitor checks every accepted word.
module tb_etroc2_fifo_word_packer;

    localparam logic [39:0] PAD = 40'hFFFFFFFFFF;

    logic        clk40 = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic        flush = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [39:0] fifo_dout = '0;
    logic        fifo_rd_en;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        busy;
    logic [31:0] group_count;
    logic [15:0] pad_count;

    etroc2_fifo_word_packer #(
        .FLUSH_TIMEOUT(16),
        .PAD_WORD(PAD)
    ) dut (
        .clk40(clk40),
        .reset(reset),
        .enable(enable),
        .flush(flush),
        .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .dout(dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .busy(busy),
        .group_count(group_count),
        .pad_count(pad_count)
    );

    always #5 clk40 = ~clk40;

    int checks = 0;
    int failures = 0;
    int rdCycles = 0;
    int acceptCnt = 0;
    int readyPct = 100;
    int groupsExp = 0;
    int padsExp = 0;

    logic [39:0] fq[$];
    logic [39:0] modelPend[$];
    logic [39:0] grp[$];
    logic [31:0] expQ[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference model: groups of four 40-bit words concatenated MSB-first, cut into 32-bit words.
    function automatic void emitGroup();
        logic [159:0] p;
        p = {grp[0], grp[1], grp[2], grp[3]};
        for (int k = 0; k < 5; k++) expQ.push_back(p[159 - 32*k -: 32]);
        grp.delete();
        groupsExp++;
    endfunction

    function automatic void absorb();
        while (modelPend.size() > 0) begin
            grp.push_back(modelPend.pop_front());
            if (grp.size() == 4) emitGroup();
        end
    endfunction

    function automatic void closePartial();
        if (grp.size() != 0) begin
            padsExp += 4 - grp.size();
            while (grp.size() < 4) grp.push_back(PAD);
            emitGroup();
        end
    endfunction

    // Standard (non-FWFT) FIFO: data appears the cycle after the read strobe.
    always @(posedge clk40) begin
        if (fifo_rd_en) begin
            rdCycles++;
            if (fq.size() > 0) fifo_dout <= fq.pop_front();
        end
        fifo_empty <= (fq.size() == 0);
    end

    logic [31:0] heldDout = '0;
    logic        stalled = 1'b0;

    always @(negedge clk40) begin
        dout_ready = ($urandom_range(0, 99) < readyPct);
        if (!reset) begin
            stalled = 1'b0;
        end else if (dout_valid) begin
            if (stalled) check("hold_stable", dout, heldDout);
            if (dout_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %h, expected no output", dout);
                end else begin
                    check("dout_word", dout, expQ.pop_front());
                end
                acceptCnt++;
                $display("word %0d: dout=%h", acceptCnt, dout);
                stalled = 1'b0;
            end else begin
                stalled  = 1'b1;
                heldDout = dout;
            end
        end else begin
            if (stalled) check("valid_held", {63'b0, dout_valid}, 64'd1);
            stalled = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk40);
            #2;
        end
    endtask

    task automatic fifoPush(input logic [39:0] w);
        fq.push_back(w);
        modelPend.push_back(w);
    endtask

    task automatic pulseFlush();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
    endtask

    task automatic waitFifoEmpty();
        int g = 0;
        while (fq.size() != 0 && g < 300) begin
            tick(1);
            g++;
        end
        if (g >= 300) begin
            checks++;
            failures++;
            $display("FAIL fifo_drain_timeout: got %0d words left, expected 0", fq.size());
        end
    endtask

    task automatic drain();
        int g = 0;
        while (expQ.size() != 0 && g < 500) begin
            tick(1);
            g++;
        end
        if (g >= 500) begin
            checks++;
            failures++;
            $display("FAIL output_timeout: got %0d words pending, expected 0", expQ.size());
        end
        tick(2);
    endtask

    task automatic checkCounters(input string tag);
        check({tag, "_group_count"}, group_count, groupsExp);
        check({tag, "_pad_count"}, pad_count, padsExp);
    endtask

    initial begin
        int rd0;
        int lat;
        int target;
        int g;
        logic sawActive;

        // Reset with data waiting: nothing may be read while reset is held.
        fifoPush(40'h1122334455);
        tick(4);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_rd_cycles", rdCycles, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_busy", busy, 0);
        checkCounters("rst");
        reset = 1'b1;

        // Single word then explicit flush: three pad slots.
        absorb();
        waitFifoEmpty();
        tick(3);
        pulseFlush();
        closePartial();
        drain();
        checkCounters("single_flush");
        check("single_flush_busy", busy, 0);

        // Full group with known data and exactly four reads.
        rd0 = rdCycles;
        fifoPush(40'h0123456789);
        fifoPush(40'hABCDEF0123);
        fifoPush(40'h456789ABCD);
        fifoPush(40'hEF01234567);
        absorb();
        drain();
        check("full_rd_cycles", rdCycles - rd0, 4);
        checkCounters("full");

        // Two words then silence: the idle timeout closes the group.
        fifoPush(40'hA5A5A5A5A5);
        fifoPush(40'h5A5A5A5A5A);
        absorb();
        closePartial();
        waitFifoEmpty();
        lat = 0;
        while (!dout_valid && lat < 60) begin
            @(negedge clk40);
            lat++;
        end
        checks++;
        if (lat < 17 || lat > 21) begin
            failures++;
            $display("FAIL timeout_latency: got %0d cycles, expected 17..21", lat);
        end
        drain();
        checkCounters("timeout");

        // Flush with nothing held: ignored, block stays idle.
        pulseFlush();
        sawActive = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (busy || dout_valid) sawActive = 1'b1;
        end
        check("idle_flush_active", sawActive, 0);
        checkCounters("idle_flush");

        // enable low blocks reads; a held partial group waits for an explicit flush.
        enable = 1'b0;
        rd0 = rdCycles;
        fifoPush(40'h0000000001);
        fifoPush(40'h0000000002);
        tick(10);
        check("en_off_rd_cycles", rdCycles - rd0, 0);
        check("en_off_busy", busy, 0);
        absorb();
        enable = 1'b1;
        waitFifoEmpty();
        tick(3);
        check("en_loaded_busy", busy, 1);
        enable = 1'b0;
        rd0 = rdCycles;
        fifoPush(40'h0000000003);
        fifoPush(40'h0000000004);
        tick(24);
        check("en_drop_rd_cycles", rdCycles - rd0, 0);
        check("en_drop_no_output", dout_valid, 0);
        pulseFlush();
        closePartial();
        drain();
        checkCounters("en_drop_flush");
        absorb();
        enable = 1'b1;
        waitFifoEmpty();
        tick(3);
        pulseFlush();
        closePartial();
        drain();
        checkCounters("en_resume");

        // Reset after two of five words are accepted, with ready toggling.
        readyPct = 50;
        for (int i = 0; i < 4; i++) fifoPush({8'($urandom), $urandom});
        absorb();
        target = acceptCnt + 2;
        g = 0;
        while (acceptCnt < target && g < 300) begin
            tick(1);
            g++;
        end
        check("mid_reset_reached", {63'b0, acceptCnt >= target}, 64'd1);
        reset = 1'b0;
        expQ.delete();
        grp.delete();
        modelPend.delete();
        groupsExp = 0;
        padsExp = 0;
        tick(1);
        check("mid_reset_valid", dout_valid, 0);
        check("mid_reset_busy", busy, 0);
        checkCounters("mid_reset");
        tick(1);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) fifoPush({8'($urandom), $urandom});
        absorb();
        drain();
        checkCounters("post_reset");

        // Randomized bursts, each closed by flush or by the idle timeout.
        for (int r = 0; r < 8; r++) begin
            int n;
            readyPct = $urandom_range(30, 100);
            n = $urandom_range(1, 11);
            for (int i = 0; i < n; i++) begin
                fifoPush({8'($urandom), $urandom});
                absorb();
                tick($urandom_range(1, 3));
            end
            if (grp.size() != 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    waitFifoEmpty();
                    tick(3);
                    pulseFlush();
                end
                closePartial();
            end
            drain();
            checkCounters("random");
            check("random_busy", busy, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/etroc2_fifo_word_packer.md
Name: etroc2_fifo_word_packer

Overview:
Downstream consumer of the per-channel ETROC2 40-bit readout FIFO (the 1K-deep clk40 FIFO filled by the frame-sync stage). Reads 40-bit words and repacks each group of 4 words (160 bits) into 5 32-bit words for the DAQ readout path, using a valid/ready output handshake. Partial groups are padded and flushed on request or after an empty-FIFO timeout, so no data is stranded at session end.

Parameters:
FLUSH_TIMEOUT, 1024, consecutive cycles with FIFO empty and a partial group held before an automatic flush; 0 disables the timeout.
PAD_WORD, 40'hFFFFFFFFFF, 40-bit value inserted into unfilled slots on a flush.

Ports:
clk40  input  1  system clock; all logic is on its rising edge.
reset  input  1  synchronous reset, active-low.
enable  input  1  when low, no new FIFO reads are issued; a group already in progress still completes.
flush  input  1  single-cycle pulse requesting a pad-and-emit of the current partial group.
fifo_empty  input  1  FIFO empty flag.
fifo_dout  input  40  FIFO read data, valid the cycle after fifo_rd_en (standard, non-FWFT).
fifo_rd_en  output  1  FIFO read strobe.
dout  output  32  packed output word.
dout_valid  output  1  dout holds a valid word.
dout_ready  input  1  downstream accepts the word when valid and ready are both high.
busy  output  1  high while the group is non-empty, a read is in flight, or the block is in EMIT.
group_count  output  32  number of 5-word groups fully emitted; wraps.
pad_count  output  16  number of pad slots inserted; saturates at 16'hFFFF.

Behaviour:
- Reset (reset == 0 at a clk40 edge) clears all state. Reset values: fifo_rd_en=0, dout=0, dout_valid=0, busy=0, group_count=0, pad_count=0, state=FILL, loaded=0, no read in flight, flush pending cleared. A reset mid-group discards the partial group and any in-flight word.
- Storage: four 40-bit slots s0..s3. loaded counts 0..4. inflight counts 0..1.
- State FILL:
  - fifo_rd_en = enable & ~fifo_empty & (loaded + inflight < 4) & ~flush_pending.
  - On the cycle after a read, fifo_dout is written into slot[loaded] and loaded increments.
  - Back-to-back reads are allowed, giving one word per cycle.
  - When loaded reaches 4, go to EMIT.
- Flush:
  - A flush pulse, or the timeout expiring, sets flush_pending only if loaded + inflight > 0. Otherwise the request is ignored.
  - The timeout counter increments while 0 < loaded < 4 and fifo_empty is high, and clears on any read or on leaving FILL.
  - While flush_pending is set, no new reads are issued. Once inflight = 0, slots loaded..3 are filled with PAD_WORD, pad_count increases by (4 - loaded), and the state goes to EMIT.
  - A flush arriving while in EMIT is ignored.
- State EMIT:
  - Define P = {s0, s1, s2, s3}, with s0 as the MSBs. Word k (k = 0..4) is P[159-32k -: 32].
  - dout_valid is registered and asserts the cycle after entering EMIT.
  - dout and dout_valid hold stable until accepted. Deasserting dout_ready never changes dout.
  - On acceptance of word 4: group_count increments, loaded clears to 0, flush_pending clears, and the state returns to FILL.
  - dout_valid deasserts in the same cycle word 4 is accepted, giving no bubble beyond one cycle.
- Throughput: at most 4 reads in 4 cycles, then 5 output words in 5 cycles when dout_ready stays high.
- No FIFO read is issued in EMIT.
- fifo_empty going high between rd_en and data return has no effect; a read already in flight always lands.

Test Plan:
- Reset, then write 40'h0123456789, 40'hABCDEF0123, 40'h456789ABCD, 40'hEF01234567 with dout_ready=1 -> dout sequence 01234567, 89ABCDEF, 01234567, 89ABCDEF, 01234567; group_count=1; pad_count=0; fifo_rd_en high for exactly 4 cycles.
- Single word 40'h1122334455, then a flush pulse -> 11223344, 55FFFFFF, FFFFFFFF, FFFFFFFF, FFFFFFFF; pad_count=3; group_count=1.
- FLUSH_TIMEOUT=16, two words, then FIFO empty -> auto-flush when fifo_empty has been high 16 cycles; emits 5 words; pad_count=2. A flush pulse with loaded=0 -> no output; busy stays 0.
- Toggle dout_ready pseudo-randomly during EMIT -> dout stable while valid & ~ready; 5 words in order; no duplicates or drops.
- Assert reset low after 2 of 5 words are accepted -> next cycle dout_valid=0, group_count=0; the next full 4-word group emits correctly from word 0.
- enable=0 with a non-empty FIFO -> fifo_rd_en stays 0. Drop enable with loaded=2 -> no further reads; the group completes only via flush or timeout.
